// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit feeding the HI/LO register pair.
// The sign of each operand is stripped on accept. A magnitude-only shift-add
// (multiply) or restoring (divide) datapath then runs for 32 iterations. The
// sign is re-applied in FIX, and WRITE issues a single strobe cycle.
//
// Write-port handshake: write_hi/write_lo are a one-cycle valid strobe with no
// ready; the HI/LO register must capture out_hi/out_lo on every edge where the
// strobes are high. start is a request that is taken only when busy=0 and
// cancel=0; it is never queued.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    output logic        busy,
    output logic        write_hi,
    output logic        write_lo,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        res_neg_q;
    logic        rem_neg_q;
    logic        div0_q;
    logic [31:0] rs_orig_q;
    logic [31:0] mcand_q;   // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_q;     // upper product half or partial remainder
    logic [31:0] lo_q;      // multiplier (shifted out) / dividend-quotient
    logic [31:0] out_hi_q;
    logic [31:0] out_lo_q;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] hi_res, lo_res;

    assign accept = (state_q == S_IDLE) && start && !cancel;

    // Signed ops (op[0]=0) work on magnitudes; unsigned ops pass operands through.
    assign a_neg = ~op[0] & rs_data[31];
    assign b_neg = ~op[0] & rt_data[31];
    assign a_mag = a_neg ? (~rs_data + 32'd1) : rs_data;
    assign b_mag = b_neg ? (~rt_data + 32'd1) : rt_data;

    // One iteration of each datapath; the carry lands in the product's top bit.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign div_shift = {acc_q, lo_q[31]};
    assign div_trial = div_shift - {1'b0, mcand_q};

    // Sign correction and result selection used in FIX.
    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = res_neg_q ? (~prod + 64'd1) : prod;
        quo_fix  = res_neg_q ? (~lo_q + 32'd1) : lo_q;
        rem_fix  = rem_neg_q ? (~acc_q + 32'd1) : acc_q;
        hi_res   = prod_fix[63:32];
        lo_res   = prod_fix[31:0];
        if (is_div_q) begin
            if (div0_q) begin
                hi_res = rs_orig_q;
                lo_res = 32'hFFFF_FFFF;
            end else begin
                hi_res = rem_fix;
                lo_res = quo_fix;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; cancel aborts from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
    end

    // Operand capture, iteration, and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_orig_q <= 32'd0;
            mcand_q   <= 32'd0;
            acc_q     <= 32'd0;
            lo_q      <= 32'd0;
            out_hi_q  <= 32'd0;
            out_lo_q  <= 32'd0;
        end else begin
            if (accept) begin
                cnt_q     <= 5'd0;
                is_div_q  <= op[1];
                res_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                div0_q    <= op[1] & (rt_data == 32'd0);
                rs_orig_q <= rs_data;
                mcand_q   <= op[1] ? b_mag : a_mag;
                lo_q      <= op[1] ? a_mag : b_mag;
                acc_q     <= 32'd0;
            end else if (state_q == S_RUN && !cancel) begin
                cnt_q <= cnt_q + 5'd1;
                if (is_div_q) begin
                    if (!div_trial[32]) begin
                        acc_q <= div_trial[31:0];
                        lo_q  <= {lo_q[30:0], 1'b1};
                    end else begin
                        acc_q <= div_shift[31:0];
                        lo_q  <= {lo_q[30:0], 1'b0};
                    end
                end else begin
                    acc_q <= mul_sum[32:1];
                    lo_q  <= {mul_sum[0], lo_q[31:1]};
                end
            end else if (state_q == S_FIX && !cancel) begin
                out_hi_q <= hi_res;
                out_lo_q <= lo_res;
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign write_hi    = (state_q == S_WRITE) && !cancel;
    assign write_lo    = (state_q == S_WRITE) && !cancel;
    assign out_hi      = out_hi_q;
    assign out_lo      = out_lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit products, truncating division).
module tb_muldiv_unit;

  localparam int HORIZON = 72;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          strobe_cyc_q[$];
  int          strobe_split;
  logic        busy_log[0:79];
  logic        zero_log[0:79];

  muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .cancel      (cancel),
    .busy        (busy),
    .write_hi    (write_hi),
    .write_lo    (write_lo),
    .out_hi      (out_hi),
    .out_lo      (out_lo),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa * sb;
        res = q;
      end
      2'b01: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (o == 2'b10) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // driver: issue one op, then watch HORIZON cycles; optional second start,
  // cancel and reset injected during cycle N after the accept edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_cyc, input int reset_cyc, input int start2_cyc,
                        input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] b2);
    strobe_cyc_q.delete();
    obs_q.delete();
    strobe_split = 0;
    for (int i = 0; i < 80; i++) begin
      busy_log[i] = 1'b0;
      zero_log[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; cancel = 1'b0;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    for (int c = 1; c <= HORIZON; c++) begin
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; reset = 1'b0;
      op = 2'($urandom_range(0, 3)); rs_data = $urandom; rt_data = $urandom;
      if (c == start2_cyc) begin start = 1'b1; op = o2; rs_data = a2; rt_data = b2; end
      if (c == cancel_cyc) cancel = 1'b1;
      if (c == reset_cyc) reset = 1'b1;
      #1;
      busy_log[c] = busy;
      zero_log[c] = (busy === 1'b0) && (write_hi === 1'b0) && (write_lo === 1'b0) &&
                    (out_hi === 32'd0) && (out_lo === 32'd0);
      if (write_hi !== write_lo) strobe_split++;
      if (write_hi === 1'b1) begin
        strobe_cyc_q.push_back(c);
        obs_q.push_back({out_hi, out_lo});
      end
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; cancel = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (write_hi !== 1'b0 || write_lo !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b%b want 00", write_hi, write_lo);
    end
    n_checks++;
    if (out_hi !== 32'd0 || out_lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got %h_%h want 0_0", out_hi, out_lo);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  vo[10];
    logic [31:0] va[10];
    logic [31:0] vb[10];
    logic [63:0] ve[10];
    logic [63:0] e;
    vo[0] = 2'b01; va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 64'hFFFF_FFFE_0000_0001;
    vo[1] = 2'b00; va[1] = 32'hFFFF_FFFD; vb[1] = 32'd5;         ve[1] = 64'hFFFF_FFFF_FFFF_FFF1;
    vo[2] = 2'b00; va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; ve[2] = 64'h4000_0000_0000_0000;
    vo[3] = 2'b10; va[3] = 32'hFFFF_FFF9; vb[3] = 32'd2;         ve[3] = 64'hFFFF_FFFF_FFFF_FFFD;
    vo[4] = 2'b11; va[4] = 32'd7;         vb[4] = 32'd2;         ve[4] = 64'h0000_0001_0000_0003;
    vo[5] = 2'b10; va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_FFFF; ve[5] = 64'h0000_0000_8000_0000;
    vo[6] = 2'b11; va[6] = 32'd100;       vb[6] = 32'd0;         ve[6] = 64'h0000_0064_FFFF_FFFF;
    vo[7] = 2'b10; va[7] = 32'hFFFF_FF9C; vb[7] = 32'd0;         ve[7] = 64'hFFFF_FF9C_FFFF_FFFF;
    vo[8] = 2'b10; va[8] = 32'd7;         vb[8] = 32'hFFFF_FFFE; ve[8] = 64'h0000_0001_FFFF_FFFD;
    vo[9] = 2'b01; va[9] = 32'd0;         vb[9] = 32'h1234_5678; ve[9] = 64'h0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ve[i]);
      run_op(vo[i], va[i], vb[i], -1, -1, -1, 2'b00, 32'd0, 32'd0);
      e = exp_q.pop_front();
      n_checks++;
      if (strobe_cyc_q.size() != 1 || strobe_cyc_q[0] != 34) begin
        n_fail++;
        $display("FAIL dir%0d_strobe: got %0d pulses first at %0d want 1 at 34", i,
                 strobe_cyc_q.size(), (strobe_cyc_q.size() > 0) ? strobe_cyc_q[0] : -1);
      end else begin
        n_checks++;
        if (obs_q[0] !== e) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, obs_q[0], e); end
      end
      n_checks++;
      if (busy_log[1] !== 1'b1 || busy_log[34] !== 1'b1 || busy_log[35] !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_busy: got c1=%b c34=%b c35=%b want 1 1 0", i, busy_log[1], busy_log[34], busy_log[35]);
      end
      n_checks++;
      if (strobe_split != 0) begin n_fail++; $display("FAIL dir%0d_split: got %0d want 0", i, strobe_split); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp_q.push_back(model(o, a, b));
      run_op(o, a, b, -1, -1, -1, 2'b00, 32'd0, 32'd0);
      e = exp_q.pop_front();
      n_checks++;
      if (strobe_cyc_q.size() != 1 || strobe_cyc_q[0] != 34) begin
        n_fail++;
        $display("FAIL rnd%0d_strobe: got %0d pulses want 1 at 34 (op %0d a %h b %h)", i, strobe_cyc_q.size(), o, a, b);
      end else begin
        n_checks++;
        if (obs_q[0] !== e) begin
          n_fail++; $display("FAIL rnd%0d_data: got %h want %h (op %0d a %h b %h)", i, obs_q[0], e, o, a, b);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] e;
    exp_q.push_back(64'd42);
    run_op(2'b01, 32'd6, 32'd7, -1, -1, 10, 2'b11, 32'd100, 32'd3);
    e = exp_q.pop_front();
    n_checks++;
    if (strobe_cyc_q.size() != 1 || strobe_cyc_q[0] != 34) begin
      n_fail++; $display("FAIL busy_start_strobe: got %0d pulses want 1 at 34", strobe_cyc_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== e) begin n_fail++; $display("FAIL busy_start_data: got %h want %h", obs_q[0], e); end
    end
  endtask

  task automatic test_cancel_mid();
    logic [63:0] e;
    exp_q.push_back(64'h0000_0001_0000_0003);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 10, -1, 11, 2'b11, 32'd7, 32'd2);
    e = exp_q.pop_front();
    n_checks++;
    if (busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0) begin
      n_fail++; $display("FAIL cancel_busy: got c10=%b c11=%b want 1 0", busy_log[10], busy_log[11]);
    end
    n_checks++;
    if (strobe_cyc_q.size() != 1 || strobe_cyc_q[0] != 45) begin
      n_fail++; $display("FAIL cancel_restart_strobe: got %0d pulses want 1 at 45", strobe_cyc_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== e) begin n_fail++; $display("FAIL cancel_restart_data: got %h want %h", obs_q[0], e); end
    end
  endtask

  task automatic test_cancel_write();
    run_op(2'b01, 32'd9, 32'd9, 34, -1, -1, 2'b00, 32'd0, 32'd0);
    n_checks++;
    if (strobe_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL cancel_write_strobe: got %0d pulses want 0", strobe_cyc_q.size());
    end
    n_checks++;
    if (busy_log[35] !== 1'b0) begin n_fail++; $display("FAIL cancel_write_busy: got %b want 0", busy_log[35]); end
  endtask

  task automatic test_cancel_start_idle();
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_vs_start: got busy %b want 0", busy); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || write_hi !== 1'b0) begin
      n_fail++; $display("FAIL cancel_vs_start_late: got busy %b strobe %b want 0 0", busy, write_hi);
    end
  endtask

  task automatic test_reset_mid();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 20, -1, 2'b00, 32'd0, 32'd0);
    n_checks++;
    if (strobe_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_strobe: got %0d pulses want 0", strobe_cyc_q.size());
    end
    n_checks++;
    if (zero_log[21] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_outputs: got %b want all-zero 1", zero_log[21]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    exp_q.push_back(64'h0000_0001_0000_0003);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1, 35, 2'b11, 32'd7, 32'd2);
    n_checks++;
    if (strobe_cyc_q.size() != 2 || strobe_cyc_q[0] != 34 || strobe_cyc_q[1] != 69) begin
      n_fail++; $display("FAIL b2b_strobes: got %0d pulses want 2 at 34 and 69", strobe_cyc_q.size());
      exp_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q[i] !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, obs_q[i], e); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_cancel_mid();
    test_cancel_write();
    test_cancel_start_idle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit that produces the results written into the CPU's HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide datapath. It then drives one-cycle write strobes plus 32-bit HI/LO data directly into the HI/LO register's write port. Its `busy` output lets the hazard unit stall MFHI/MFLO and any new mul/div until the result has been committed.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; accepted only on an edge where `busy`=0 and `cancel`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on accept.
- `rs_data`  in  32  multiplicand / dividend; sampled on accept.
- `rt_data`  in  32  multiplier / divisor; sampled on accept.
- `cancel`  in  1  abort the in-flight operation (pipeline flush/exception).
- `busy`  out  1  operation in flight; high from the cycle after accept through the write cycle.
- `write_hi`  out  1  one-cycle write strobe to HI.
- `write_lo`  out  1  one-cycle write strobe to LO.
- `out_hi`  out  32  HI result; valid while strobes are high.
- `out_lo`  out  32  LO result; valid while strobes are high.

## Operation
- States:
  - IDLE: accept on `start`.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign correction and result load.
  - WRITE: strobe.
  - Transitions: IDLE -> RUN -> FIX -> WRITE -> IDLE.
- Reset: state IDLE; `busy`, `write_hi`, `write_lo` = 0; `out_hi`/`out_lo` = 0; counter and operand registers cleared.
- Operand capture on accept:
  - Signed ops (MULT, DIV): store magnitudes of `rs_data` and `rt_data`.
  - Record result sign = sign(rs) XOR sign(rt), and remainder sign = sign(rs).
  - Unsigned ops: store operands unmodified; both sign flags 0.
- Multiply: 64-bit shift-add over 32 iterations.
  - FIX: negate the 64-bit product if the result sign is set.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division over 32 iterations, producing a 32-bit quotient and 33-bit partial remainder.
  - FIX: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
  - LO = quotient, HI = remainder.
- Divide by zero (`rt_data`=0 at accept, DIV or DIVU):
  - Iterations still run; FIX forces LO = 0xFFFFFFFF and HI = original `rs_data`.
  - Latency is unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0. This falls out of the magnitude datapath; no special case is needed.
- `out_hi`/`out_lo` are loaded in FIX and hold until the next FIX or reset.
- `write_hi` = `write_lo` = (state==WRITE) AND NOT `cancel`. Both strobes are always asserted together.

## Timing
- Accept on edge E0. Cycles after E0:
  - Cycles 1-32: RUN, `busy`=1.
  - Cycle 33: FIX, `busy`=1.
  - Cycle 34: WRITE, with strobes and data valid and `busy`=1.
  - Cycle 35: IDLE, `busy`=0; the HI/LO register already holds the result.
  - Fixed latency: 34 cycles from accept to strobe.
- Earliest next accept is on the edge ending cycle 35; back-to-back ops are spaced 35 cycles.
- `start` while `busy`=1: ignored, not queued; the in-flight op is unaffected.
- `cancel` on any edge while not IDLE:
  - State returns to IDLE; `busy`=0 next cycle.
  - No strobe is ever issued for the aborted op.
  - `cancel` during the WRITE cycle suppresses the strobes combinationally in that same cycle.
- `cancel` and `start` on the same edge in IDLE: cancel wins; nothing is accepted.
- `reset` mid-operation: IDLE next cycle, all outputs return to reset values, no strobe.
- Operand inputs are don't-care after accept.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, accepted at E0 -> at cycle 34 `write_hi`=`write_lo`=1, HI=0xFFFFFFFE, LO=0x00000001; `busy`=0 at cycle 35.
- MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 and DIV 0xFFFFFF9C / 0 -> LO=0xFFFFFFFF, HI equal to the dividend (0x64 and 0xFFFFFF9C respectively), strobes at cycle 34.
- Start while busy, e.g. a second start at cycle 10 with different operands -> ignored; the first result still appears at cycle 34 with exactly one strobe pulse.
- Cancel scenarios:
  - Cancel at cycle 10 -> no strobe, `busy`=0 at cycle 11; a new start at cycle 11 completes normally 34 cycles later.
  - Cancel asserted in the WRITE cycle -> strobes stay 0.
  - Reset at cycle 20 -> all outputs 0 and no strobe.
